sram_port_arbiter: RTL

Two-requester arbiter and sequencer for the RW port (port 0) of the 1RW1R 32x256x8 SRAM macro. It accepts read/write transactions from two fabric-side requesters (A, B) over valid/ready handshakes and drives the macro's registered-input, active-low control pins. It also routes each read result back to the requester that issued it. The block sits between the BRAM interface tile logic and the SRAM macro; port 1 is not served and is held deselected.

---
 rtl/sram_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Arbitrates two fabric requesters (A, B) onto the RW port (port 0) of the
//   1RW1R 32x256x8 SRAM macro and routes each read result back to its issuer.
//   Port 1 of the macro is held deselected.
//
//   Build option: define SRAM_ARB_RR_EN for round-robin arbitration between
//   A and B; when it is undefined A has fixed priority over B.
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   {a,b}_valid/_ready       request handshake (ready is combinational)
//   {a,b}_we/_wmask/_addr/_wdata  request payload
//   {a,b}_rvalid/_rdata      one-cycle read strobe, data held until next strobe
//   csb0/web0/wmask0/addr0/din0   registered, active-low macro port 0 controls
//   dout0                    macro port 0 read data
//   csb1                     macro port 1 select, tied inactive
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  csb1
);

    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;

    logic grant_a;
    logic grant_b;

`ifdef SRAM_ARB_RR_EN
    // Requester granted most recently; starts at B so A wins the first conflict.
    req_id_e last_grant;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant <= REQ_B;
        end else if (grant_a) begin
            last_grant <= REQ_A;
        end else if (grant_b) begin
            last_grant <= REQ_B;
        end
    end

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!RST) begin
            if (a_valid && (!b_valid || last_grant == REQ_B)) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end
`else
    always_comb begin
        grant_a = !RST && a_valid;
        grant_b = !RST && b_valid && !a_valid;
    end
`endif

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign csb1    = 1'b1;

    logic                  grant;
    logic                  sel_we;
    logic [NUM_WMASKS-1:0] sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    always_comb begin
        grant     = grant_a || grant_b;
        sel_we    = grant_b ? b_we    : a_we;
        sel_wmask = grant_b ? b_wmask : a_wmask;
        sel_addr  = grant_b ? b_addr  : a_addr;
        sel_wdata = grant_b ? b_wdata : a_wdata;
    end

    // Macro pins; addr0/din0 hold on idle cycles to avoid needless toggling.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= '0;
            din0   <= '0;
        end else if (grant) begin
            csb0   <= 1'b0;
            web0   <= ~sel_we;
            wmask0 <= sel_we ? sel_wmask : '0;
            addr0  <= sel_addr;
            din0   <= sel_wdata;
        end else begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
        end
    end

    // Read tag pipeline: stage 1 covers the macro's input register, stage 2
    // the cycle in which dout0 settles; the stage-2 tag steers the capture.
    logic    tag1_vld;
    req_id_e tag1_id;
    logic    tag2_vld;
    req_id_e tag2_id;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag1_vld <= 1'b0;
            tag1_id  <= REQ_A;
            tag2_vld <= 1'b0;
            tag2_id  <= REQ_A;
        end else begin
            tag1_vld <= grant && !sel_we;
            tag1_id  <= grant_b ? REQ_B : REQ_A;
            tag2_vld <= tag1_vld;
            tag2_id  <= tag1_id;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= tag2_vld && (tag2_id == REQ_A);
            b_rvalid <= tag2_vld && (tag2_id == REQ_B);
            if (tag2_vld && tag2_id == REQ_A) begin
                a_rdata <= dout0;
            end
            if (tag2_vld && tag2_id == REQ_B) begin
                b_rdata <= dout0;
            end
        end
    end

endmodule
